// File: rtl/dll_trunc_index_ctrl.sv
// Closed-loop truncation-index controller: tracks peak leading-one position of accumulator dumps per window
// and steers index_out (fast attack, slow decay). Optional override via DLL_TRUNC_INDEX_FORCE_EN.
module dll_trunc_index_ctrl #(
    parameter int INPUT_WIDTH  = 36,
    parameter int OUTPUT_WIDTH = 11,
    parameter int INDEX_WIDTH  = 6,
    parameter int WINDOW_LOG2  = 3,
    parameter int HEADROOM     = 1,
    parameter int INDEX_INIT   = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   acc_valid,
    input  logic [INPUT_WIDTH-1:0] acc_in,
`ifdef DLL_TRUNC_INDEX_FORCE_EN
    input  logic                   force_en,
    input  logic [INDEX_WIDTH-1:0] force_index,
`endif
    output logic [INDEX_WIDTH-1:0] index_out,
    output logic                   index_update,
    output logic [7:0]             clip_count,
    output logic [INDEX_WIDTH-1:0] window_peak
);

    localparam logic [INDEX_WIDTH-1:0] IDX_LO   = INDEX_WIDTH'(OUTPUT_WIDTH - 1);
    localparam logic [INDEX_WIDTH-1:0] IDX_HI   = INDEX_WIDTH'(INPUT_WIDTH - 1);
    localparam logic [INDEX_WIDTH-1:0] IDX_INIT = INDEX_WIDTH'(INDEX_INIT);
    localparam logic [INDEX_WIDTH:0]   IDX_LO_W = {1'b0, IDX_LO};
    localparam logic [INDEX_WIDTH:0]   IDX_HI_W = {1'b0, IDX_HI};
    localparam logic [INDEX_WIDTH:0]   TGT_OFS  = (INDEX_WIDTH+1)'(1 + HEADROOM);
    localparam logic [INDEX_WIDTH:0]   DECAY_GAP = (INDEX_WIDTH+1)'(2);

    function automatic logic [INDEX_WIDTH-1:0] lead_one(input logic [INPUT_WIDTH-2:0] v);
        logic [INDEX_WIDTH-1:0] pos;
        pos = '0;
        for (int i = 0; i < INPUT_WIDTH - 1; i++) begin
            if (v[i]) pos = INDEX_WIDTH'(i);
        end
        return pos;
    endfunction

    logic                   s1_valid_q, s1_valid_d;
    logic [INDEX_WIDTH-1:0] s1_p_q, s1_p_d;
    logic [WINDOW_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [INDEX_WIDTH-1:0] max_q, max_d;
    logic [7:0]             clip_acc_q, clip_acc_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic                   index_update_q, index_update_d;
    logic [7:0]             clip_count_q, clip_count_d;
    logic [INDEX_WIDTH-1:0] window_peak_q, window_peak_d;

    logic [INPUT_WIDTH-2:0] low_bits;
    logic [INPUT_WIDTH-2:0] mag;
    logic                   clip_hit;
    logic [INDEX_WIDTH-1:0] max_new;
    logic [7:0]             clip_new;
    logic                   win_last;
    logic [INDEX_WIDTH:0]   target_raw;
    logic [INDEX_WIDTH:0]   target_w;
    logic [INDEX_WIDTH:0]   index_w;

    // Stage 1: magnitude (most-negative input saturates) and its leading-one position
    always_comb begin
        low_bits = acc_in[INPUT_WIDTH-2:0];
        mag      = low_bits;
        if (acc_in[INPUT_WIDTH-1]) begin
            if (low_bits == '0) mag = '1;
            else                mag = (INPUT_WIDTH-1)'(~low_bits + 1'b1);
        end
        s1_valid_d = acc_valid & ~clear;
        s1_p_d     = lead_one(mag);
    end

    // Stage 2: window statistics and index adaptation
    always_comb begin
        clip_hit = (s1_p_q >= index_q);
        max_new  = (s1_p_q > max_q) ? s1_p_q : max_q;
        clip_new = (clip_acc_q == 8'hFF) ? 8'hFF : clip_acc_q + {7'd0, clip_hit};
        win_last = s1_valid_q && (win_cnt_q == '1);

        target_raw = {1'b0, max_new} + TGT_OFS;
        target_w   = target_raw;
        if (target_raw < IDX_LO_W) target_w = IDX_LO_W;
        if (target_raw > IDX_HI_W) target_w = IDX_HI_W;
        index_w = {1'b0, index_q};

        win_cnt_d      = win_cnt_q;
        max_d          = max_q;
        clip_acc_d     = clip_acc_q;
        index_d        = index_q;
        index_update_d = 1'b0;
        clip_count_d   = clip_count_q;
        window_peak_d  = window_peak_q;

        if (s1_valid_q) begin
            win_cnt_d = win_cnt_q + 1'b1;
            if (win_last) begin
                index_update_d = 1'b1;
                window_peak_d  = max_new;
                clip_count_d   = clip_new;
                max_d          = '0;
                clip_acc_d     = '0;
                if (target_w > index_w) begin
                    index_d = INDEX_WIDTH'(target_w);
                end else if ((target_w + DECAY_GAP) <= index_w) begin
                    index_d = index_q - 1'b1;
                end
            end else begin
                max_d      = max_new;
                clip_acc_d = clip_new;
            end
        end

`ifdef DLL_TRUNC_INDEX_FORCE_EN
        if (force_en) begin
            if (force_index < IDX_LO)      index_d = IDX_LO;
            else if (force_index > IDX_HI) index_d = IDX_HI;
            else                           index_d = force_index;
        end
`endif

        if (clear) begin
            win_cnt_d      = '0;
            max_d          = '0;
            clip_acc_d     = '0;
            index_d        = IDX_INIT;
            index_update_d = 1'b0;
            clip_count_d   = '0;
            window_peak_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q     <= 1'b0;
            s1_p_q         <= '0;
            win_cnt_q      <= '0;
            max_q          <= '0;
            clip_acc_q     <= '0;
            index_q        <= IDX_INIT;
            index_update_q <= 1'b0;
            clip_count_q   <= '0;
            window_peak_q  <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_p_q         <= s1_p_d;
            win_cnt_q      <= win_cnt_d;
            max_q          <= max_d;
            clip_acc_q     <= clip_acc_d;
            index_q        <= index_d;
            index_update_q <= index_update_d;
            clip_count_q   <= clip_count_d;
            window_peak_q  <= window_peak_d;
        end
    end

    assign index_out    = index_q;
    assign index_update = index_update_q;
    assign clip_count   = clip_count_q;
    assign window_peak  = window_peak_q;

endmodule
